gcm_ghash_verify: RTL and testbench

GCM_GHASH_VERIFY -- requirements
Module: gcm_ghash_verify

---
 rtl/gcm_pkg.sv | 30 +++
 rtl/gcm_ghash_verify_if.sv | 59 +++++
 rtl/gf128_mul_serial.sv | 49 ++++
 rtl/gcm_ghash_verify.sv | 141 ++++++++++++++
 tb/tb_gcm_ghash_verify.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcm_pkg.sv
// GCM GHASH/tag-verify shared types: block-type and FSM enums,
// the GF(2^128) reduction constant R, and a one-bit multiply-by-x helper.
package gcm_pkg;

  typedef logic [0:127] blk_t;

  typedef enum logic [1:0] {
    BT_AAD = 2'd0,
    BT_CT  = 2'd1,
    BT_LEN = 2'd2,
    BT_RSV = 2'd3
  } blk_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULT  = 2'd1,
    S_FINAL = 2'd2
  } state_e;

  // 11100001 || 0^120, with bit 0 as the MSB
  localparam blk_t GF_R = {8'hE1, 120'd0};

  // V*x in the GCM bit ordering: right shift, reduce on the bit shifted out
  function automatic blk_t gf_mulx(input blk_t v);
    blk_t s;
    s = v >> 1;
    return v[127] ? (s ^ GF_R) : s;
  endfunction

endpackage

// File: rtl/gcm_ghash_verify_if.sv
// Block bus for gcm_ghash_verify: valid/ready input handshake with the
// block payload, plus plaintext, tag and error result strobes.
// master = block source / result sink, slave = the verifier.
interface gcm_ghash_verify_if;
  import gcm_pkg::*;

  logic       i_valid;
  logic       o_ready;
  logic       i_new_instance;
  logic [1:0] i_block_type;
  blk_t       i_data;
  blk_t       i_encrypted_cb;
  blk_t       i_h;
  blk_t       i_encrypted_j0;
  blk_t       i_tag;
  blk_t       o_plain_text;
  logic       o_pt_valid;
  blk_t       o_computed_tag;
  logic       o_tag_valid;
  logic       o_tag_match;
  logic       o_err;

  modport master (
    output i_valid,
    output i_new_instance,
    output i_block_type,
    output i_data,
    output i_encrypted_cb,
    output i_h,
    output i_encrypted_j0,
    output i_tag,
    input  o_ready,
    input  o_plain_text,
    input  o_pt_valid,
    input  o_computed_tag,
    input  o_tag_valid,
    input  o_tag_match,
    input  o_err
  );

  modport slave (
    input  i_valid,
    input  i_new_instance,
    input  i_block_type,
    input  i_data,
    input  i_encrypted_cb,
    input  i_h,
    input  i_encrypted_j0,
    input  i_tag,
    output o_ready,
    output o_plain_text,
    output o_pt_valid,
    output o_computed_tag,
    output o_tag_valid,
    output o_tag_match,
    output o_err
  );

endinterface

// File: rtl/gf128_mul_serial.sv
// Bit-serial GF(2^128) multiplier, one bit of X per cycle over 128 cycles.
// Ports: clk, rst, start_i (loads x_i/h_i), done_o (last step), z_o (product).
module gf128_mul_serial
  import gcm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  blk_t x_i,
  input  blk_t h_i,
  output logic done_o,
  output blk_t z_o
);

  blk_t       x_q;
  blk_t       z_q;
  blk_t       z_d;
  blk_t       v_q;
  logic [6:0] cnt_q;
  logic       run_q;

  assign z_d    = x_q[cnt_q] ? (z_q ^ v_q) : z_q;
  // z_o is the post-step value so the caller can capture it on done
  assign z_o    = z_d;
  assign done_o = run_q && (cnt_q == 7'd127);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      z_q   <= '0;
      v_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      x_q   <= x_i;
      z_q   <= '0;
      v_q   <= h_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      z_q   <= z_d;
      v_q   <= gf_mulx(v_q);
      cnt_q <= cnt_q + 7'd1;
      if (cnt_q == 7'd127)
        run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/gcm_ghash_verify.sv
// GCM decrypt-side GHASH accumulation, plaintext recovery and tag check.
// Ports: clk, rst (sync, active high), bus (slave side of the block bus).
module gcm_ghash_verify
  import gcm_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  gcm_ghash_verify_if.slave   bus
);

  state_e state_q;
  blk_t   y_q;
  blk_t   h_q;
  blk_t   j0_q;
  blk_t   tag_q;
  logic   len_q;
  logic   ready_q;
  blk_t   pt_q;
  logic   pt_valid_q;
  blk_t   ctag_q;
  logic   tag_valid_q;
  logic   match_q;
  logic   err_q;

  logic   accept;
  logic   is_ct;
  logic   is_len;
  logic   is_rsv;
  logic   start;
  blk_t   x_d;
  blk_t   h_d;
  blk_t   ctag_d;
  logic   mul_done;
  blk_t   mul_z;

  // ready_q is only ever set while idle
  assign accept = bus.i_valid && ready_q;

  always_comb begin
    is_ct  = 1'b0;
    is_len = 1'b0;
    is_rsv = 1'b0;
    unique case (bus.i_block_type)
      BT_CT:   is_ct  = 1'b1;
      BT_LEN:  is_len = 1'b1;
      BT_RSV:  is_rsv = 1'b1;
      default: ;
    endcase
  end

  assign start  = accept && !is_rsv;
  assign x_d    = (bus.i_new_instance ? '0 : y_q) ^ bus.i_data;
  assign h_d    = bus.i_new_instance ? bus.i_h : h_q;
  assign ctag_d = mul_z ^ j0_q;

  gf128_mul_serial u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .x_i     (x_d),
    .h_i     (h_d),
    .done_o  (mul_done),
    .z_o     (mul_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      y_q         <= '0;
      h_q         <= '0;
      j0_q        <= '0;
      tag_q       <= '0;
      len_q       <= 1'b0;
      ready_q     <= 1'b0;
      pt_q        <= '0;
      pt_valid_q  <= 1'b0;
      ctag_q      <= '0;
      tag_valid_q <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pt_valid_q  <= 1'b0;
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept && is_rsv) begin
            err_q <= 1'b1;
          end else if (accept) begin
            state_q <= S_MULT;
            ready_q <= 1'b0;
            len_q   <= is_len;
            if (bus.i_new_instance) begin
              h_q  <= bus.i_h;
              j0_q <= bus.i_encrypted_j0;
            end
            if (is_len)
              tag_q <= bus.i_tag;
            if (is_ct) begin
              pt_q       <= bus.i_data ^ bus.i_encrypted_cb;
              pt_valid_q <= 1'b1;
            end
          end
        end
        S_MULT: begin
          if (mul_done) begin
            y_q <= mul_z;
            if (len_q) begin
              // tag is registered on entry so it is valid during FINAL
              state_q     <= S_FINAL;
              ctag_q      <= ctag_d;
              match_q     <= (ctag_d == tag_q);
              tag_valid_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        S_FINAL: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready        = ready_q;
  assign bus.o_plain_text   = pt_q;
  assign bus.o_pt_valid     = pt_valid_q;
  assign bus.o_computed_tag = ctag_q;
  assign bus.o_tag_valid    = tag_valid_q;
  assign bus.o_tag_match    = match_q;
  assign bus.o_err          = err_q;

endmodule

// File: tb/tb_gcm_ghash_verify.sv
// Self-checking bench for gcm_ghash_verify: NIST vectors, timing,
// reset abort, reserved blocks and a reference-model random instance.
module tb_gcm_ghash_verify;
  import gcm_pkg::*;

  localparam blk_t H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam blk_t J0   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam blk_t C2   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam blk_t L2   = 128'h00000000000000000000000000000080;
  localparam blk_t T2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam blk_t G2   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam blk_t JUNK = 128'hdeadbeef_0badf00d_13572468_a5a5c3c3;

  localparam int K_PT  = 0;
  localparam int K_TAG = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int   kind;
    blk_t val;
    logic m;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  gcm_ghash_verify_if bus ();

  gcm_ghash_verify dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk1(input string t, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask

  task automatic chkw(input string t, input blk_t o, input blk_t e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic chki(input string t, input int o, input int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", t, o, e);
    end
  endtask

  function automatic blk_t gmul(input blk_t a, input blk_t b);
    blk_t z;
    blk_t v;
    z = '0;
    v = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) z ^= v;
      v = v[127] ? ((v >> 1) ^ {8'hE1, 120'd0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic blk_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic strobe_of(input int k);
    if (k == K_PT)  return bus.o_pt_valid;
    if (k == K_TAG) return bus.o_tag_valid;
    return bus.o_err;
  endfunction

  task automatic drive(input logic nw, input logic [1:0] bt,
                       input blk_t d, input blk_t cb, input blk_t h,
                       input blk_t j0, input blk_t tg);
    bus.i_new_instance = nw;
    bus.i_block_type   = bt;
    bus.i_data         = d;
    bus.i_encrypted_cb = cb;
    bus.i_h            = h;
    bus.i_encrypted_j0 = j0;
    bus.i_tag          = tg;
    bus.i_valid        = 1'b1;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic nw, input logic [1:0] bt,
                      input blk_t d, input blk_t cb, input blk_t h,
                      input blk_t j0, input blk_t tg);
    int n;
    n = 0;
    while (bus.o_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_wait", bus.o_ready, 1'b1);
    drive(nw, bt, d, cb, h, j0, tg);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_new_instance = 1'b0;
  endtask

  task automatic expect_out(input int budget);
    exp_t e;
    int   n;
    logic seen;
    n = 0;
    chk1("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    seen = strobe_of(e.kind);
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = strobe_of(e.kind);
    end
    chk1($sformatf("strobe_kind%0d", e.kind), seen, 1'b1);
    if (seen && e.kind == K_PT)
      chkw("plain_text", bus.o_plain_text, e.val);
    if (seen && e.kind == K_TAG) begin
      chkw("computed_tag", bus.o_computed_tag, e.val);
      chk1("tag_match", bus.o_tag_match, e.m);
    end
  endtask

  task automatic chk_zero_outs(input string t);
    chkw({t, "_pt"}, bus.o_plain_text, '0);
    chkw({t, "_ctag"}, bus.o_computed_tag, '0);
    chk1({t, "_ptv"}, bus.o_pt_valid, 1'b0);
    chk1({t, "_tagv"}, bus.o_tag_valid, 1'b0);
    chk1({t, "_match"}, bus.o_tag_match, 1'b0);
    chk1({t, "_err"}, bus.o_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lowcnt;
    int   extra;
    blk_t ra, rc, rcb, rl, rh, rj, ry, rt;

    bus.i_valid = 1'b0;
    bus.i_new_instance = 1'b0;
    bus.i_block_type = 2'd0;
    bus.i_data = '0;
    bus.i_encrypted_cb = '0;
    bus.i_h = '0;
    bus.i_encrypted_j0 = '0;
    bus.i_tag = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_reset", bus.o_ready, 1'b1);

    // NIST case 1, with valid held high while busy
    sb.push_back('{kind: K_TAG, val: J0, m: 1'b1});
    drive(1'b1, 2'd2, '0, JUNK, H1, J0, J0);
    @(negedge clk);
    lowcnt = 0;
    extra = 0;
    for (int i = 0; i < 128; i++) begin
      if (bus.o_ready === 1'b0) lowcnt++;
      if (bus.o_tag_valid === 1'b1) extra++;
      @(negedge clk);
    end
    chki("busy_ready_low", lowcnt, 128);
    chki("early_tag_strobe", extra, 0);
    chk1("ready_in_final", bus.o_ready, 1'b0);
    expect_out(0);
    bus.i_valid = 1'b0;
    bus.i_new_instance = 1'b0;
    @(negedge clk);
    chk1("ready_back", bus.o_ready, 1'b1);
    chk1("tag_valid_one_cycle", bus.o_tag_valid, 1'b0);

    // NIST case 2; H/J0/tag driven with junk where they must be ignored
    sb.push_back('{kind: K_PT, val: '0, m: 1'b0});
    send(1'b1, 2'd1, C2, C2, H1, J0, JUNK);
    expect_out(0);
    @(negedge clk);
    chk1("pt_valid_one_cycle", bus.o_pt_valid, 1'b0);
    sb.push_back('{kind: K_TAG, val: T2, m: 1'b1});
    send(1'b0, 2'd2, L2, JUNK, JUNK, JUNK, T2);
    expect_out(200);
    chkw("ghash_case2", bus.o_computed_tag ^ J0, G2);
    repeat (3) @(negedge clk);
    chkw("tag_hold", bus.o_computed_tag, T2);
    chk1("match_hold", bus.o_tag_match, 1'b1);

    // case 2 with bit 127 of the received tag flipped
    sb.push_back('{kind: K_PT, val: '0, m: 1'b0});
    send(1'b1, 2'd1, C2, C2, H1, J0, JUNK);
    expect_out(0);
    sb.push_back('{kind: K_TAG, val: T2, m: 1'b0});
    send(1'b0, 2'd2, L2, JUNK, JUNK, JUNK, T2 ^ 128'h1);
    expect_out(200);

    // reset at counter 60 of the length block
    sb.push_back('{kind: K_PT, val: '0, m: 1'b0});
    send(1'b1, 2'd1, C2, C2, H1, J0, JUNK);
    expect_out(0);
    send(1'b0, 2'd2, L2, JUNK, JUNK, JUNK, T2);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outs("abort");
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_tag_valid === 1'b1 || bus.o_pt_valid === 1'b1) extra++;
    end
    chki("abort_no_strobe", extra, 0);
    chk1("abort_ready", bus.o_ready, 1'b1);
    sb.push_back('{kind: K_TAG, val: J0, m: 1'b1});
    send(1'b1, 2'd2, '0, JUNK, H1, J0, J0);
    expect_out(200);

    // reserved block mid-instance, carrying new_instance and junk keys
    sb.push_back('{kind: K_PT, val: '0, m: 1'b0});
    send(1'b1, 2'd1, C2, C2, H1, J0, JUNK);
    expect_out(0);
    sb.push_back('{kind: K_ERR, val: '0, m: 1'b0});
    send(1'b1, 2'd3, JUNK, JUNK, JUNK, JUNK, JUNK);
    expect_out(0);
    @(negedge clk);
    chk1("err_one_cycle", bus.o_err, 1'b0);
    chk1("err_stays_idle", bus.o_ready, 1'b1);
    sb.push_back('{kind: K_TAG, val: T2, m: 1'b1});
    send(1'b0, 2'd2, L2, JUNK, JUNK, JUNK, T2);
    expect_out(200);

    // random instances against the reference GHASH
    for (int r = 0; r < 2; r++) begin
      ra = rnd128();
      rc = rnd128();
      rcb = rnd128();
      rl = rnd128();
      rh = rnd128();
      rj = rnd128();
      ry = gmul(ra, rh);
      ry = gmul(ry ^ rc, rh);
      ry = gmul(ry ^ rl, rh);
      rt = ry ^ rj;
      send(1'b1, 2'd0, ra, JUNK, rh, rj, JUNK);
      sb.push_back('{kind: K_PT, val: rc ^ rcb, m: 1'b0});
      send(1'b0, 2'd1, rc, rcb, JUNK, JUNK, JUNK);
      expect_out(0);
      sb.push_back('{kind: K_TAG, val: rt, m: (r == 0)});
      send(1'b0, 2'd2, rl, JUNK, JUNK, JUNK,
           (r == 0) ? rt : (rt ^ {96'd0, 32'h10}));
      expect_out(200);
      chkw("pt_hold", bus.o_plain_text, rc ^ rcb);
    end

    chki("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
